// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared data-memory types and the arbiter's requester / lock
//                encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int MEM_SIZE   = 256;
    localparam int DATA_WIDTH = 32;

    typedef logic [DATA_WIDTH-1:0] word_t;

    typedef enum logic {REQ_CORE, REQ_DMA} req_id_t;
    typedef enum logic {UNLOCKED, LOCKED} arb_lock_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        word_t                 wdata;
    } mem_req_t;

    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ_CORE) ? REQ_DMA : REQ_CORE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_req_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_req_if
//  Description : One requester's request/response channel to the data-memory
//                arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_req_if import dmem_arbiter_pkg::*; ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic                  req_lock;
    logic [ADDR_WIDTH-1:0] req_addr;
    word_t                 req_wdata;
    logic                  rsp_valid;
    word_t                 rsp_rdata;

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface
`default_nettype wire

// File: rtl/dmem_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_rr
//  Description : Two-way round-robin picker with a bounded lock; holds the
//                last-grant and lock registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_rr import dmem_arbiter_pkg::*; #(
    parameter int MAX_LOCK = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_core_valid,
    input  logic    i_core_lock,
    input  logic    i_dma_valid,
    input  logic    i_dma_lock,
    output logic    o_grant,
    output req_id_t o_winner
);

    localparam int                 c_CNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_LOCK);

    req_id_t            r_last_grant;
    req_id_t            r_lock_owner;
    arb_lock_t          r_lock_state;
    logic [c_CNT_W-1:0] r_lock_cnt;

    req_id_t            w_lock_owner_nxt;
    arb_lock_t          w_lock_state_nxt;
    logic [c_CNT_W-1:0] w_lock_cnt_nxt;
    logic               w_win_lock;
    logic               w_other_valid;

    // Reset gates the grant so nothing reaches the memory while rst_n is low
    always_comb begin
        o_grant  = rst_n & (i_core_valid | i_dma_valid);
        o_winner = REQ_CORE;
        if (i_core_valid && !i_dma_valid) begin
            o_winner = REQ_CORE;
        end else if (i_dma_valid && !i_core_valid) begin
            o_winner = REQ_DMA;
        end else if (i_core_valid && i_dma_valid) begin
            if (r_lock_state == LOCKED && r_lock_cnt < c_MAX_CNT) begin
                o_winner = r_lock_owner;
            end else begin
                o_winner = other_req(r_last_grant);
            end
        end
    end

    assign w_win_lock    = (o_winner == REQ_CORE) ? i_core_lock : i_dma_lock;
    assign w_other_valid = (o_winner == REQ_CORE) ? i_dma_valid : i_core_valid;

    always_comb begin
        w_lock_state_nxt = r_lock_state;
        w_lock_owner_nxt = r_lock_owner;
        w_lock_cnt_nxt   = r_lock_cnt;
        if (o_grant) begin
            case (r_lock_state)
                UNLOCKED: begin
                    if (w_win_lock) begin
                        w_lock_state_nxt = LOCKED;
                        w_lock_owner_nxt = o_winner;
                        w_lock_cnt_nxt   = '0;
                    end
                end
                LOCKED: begin
                    // Any grant to the non-owner (forced or owner idle) ends the lock
                    if (o_winner != r_lock_owner || !w_win_lock) begin
                        w_lock_state_nxt = UNLOCKED;
                        w_lock_cnt_nxt   = '0;
                    end else if (w_other_valid && r_lock_cnt != c_MAX_CNT) begin
                        w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                    end
                end
                default: begin
                    w_lock_state_nxt = UNLOCKED;
                    w_lock_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= REQ_DMA;
            r_lock_owner <= REQ_CORE;
            r_lock_state <= UNLOCKED;
            r_lock_cnt   <= '0;
        end else begin
            if (o_grant) begin
                r_last_grant <= o_winner;
            end
            r_lock_owner <= w_lock_owner_nxt;
            r_lock_state <= w_lock_state_nxt;
            r_lock_cnt   <= w_lock_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : CORE/DMA arbiter for the single-port data memory; routes the
//                registered read data back to the previous cycle's owner.
//                Define DMEM_ARB_PERF_EN to add saturating grant/conflict
//                performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter import dmem_arbiter_pkg::*; #(
    parameter int MAX_LOCK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmem_req_if.slave             core,
    dmem_req_if.slave             dma,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output word_t                 mem_wdata,
    input  word_t                 mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_core_grants,
    output logic [31:0]           perf_dma_grants,
    output logic [31:0]           perf_conflicts
`endif
);

    logic     w_grant;
    req_id_t  w_winner;
    mem_req_t w_core_req;
    mem_req_t w_dma_req;
    mem_req_t w_mem_req;
    logic     w_core_rsp;
    logic     w_dma_rsp;

    logic     r_rsp_pend;
    req_id_t  r_rsp_owner;

    dmem_arb_rr #(
        .MAX_LOCK (MAX_LOCK)
    ) u_rr (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_core_valid (core.req_valid),
        .i_core_lock  (core.req_lock),
        .i_dma_valid  (dma.req_valid),
        .i_dma_lock   (dma.req_lock),
        .o_grant      (w_grant),
        .o_winner     (w_winner)
    );

    assign w_core_req = '{we: core.req_we, addr: core.req_addr, wdata: core.req_wdata};
    assign w_dma_req  = '{we: dma.req_we,  addr: dma.req_addr,  wdata: dma.req_wdata};

    always_comb begin
        w_mem_req = '0;
        if (w_grant) begin
            w_mem_req = (w_winner == REQ_CORE) ? w_core_req : w_dma_req;
        end
    end

    assign mem_we    = w_mem_req.we;
    assign mem_addr  = w_mem_req.addr;
    assign mem_wdata = w_mem_req.wdata;

    assign core.req_ready = w_grant & (w_winner == REQ_CORE);
    assign dma.req_ready  = w_grant & (w_winner == REQ_DMA);

    // Memory read data lags the grant by one cycle, so remember who it belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_pend  <= 1'b0;
            r_rsp_owner <= REQ_CORE;
        end else begin
            r_rsp_pend <= w_grant;
            if (w_grant) begin
                r_rsp_owner <= w_winner;
            end
        end
    end

    assign w_core_rsp = r_rsp_pend & (r_rsp_owner == REQ_CORE);
    assign w_dma_rsp  = r_rsp_pend & (r_rsp_owner == REQ_DMA);

    assign core.rsp_valid = w_core_rsp;
    assign core.rsp_rdata = w_core_rsp ? mem_rdata : '0;
    assign dma.rsp_valid  = w_dma_rsp;
    assign dma.rsp_rdata  = w_dma_rsp ? mem_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] r_perf_core;
    logic [31:0] r_perf_dma;
    logic [31:0] r_perf_conf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_core <= '0;
            r_perf_dma  <= '0;
            r_perf_conf <= '0;
        end else begin
            if (core.req_ready && r_perf_core != '1) r_perf_core <= r_perf_core + 1'b1;
            if (dma.req_ready  && r_perf_dma  != '1) r_perf_dma  <= r_perf_dma  + 1'b1;
            if (core.req_valid && dma.req_valid && r_perf_conf != '1) begin
                r_perf_conf <= r_perf_conf + 1'b1;
            end
        end
    end

    assign perf_core_grants = r_perf_core;
    assign perf_dma_grants  = r_perf_dma;
    assign perf_conflicts   = r_perf_conf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter with a behavioural data
//                memory and a cycle-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int MAX_LOCK = 4;

    typedef struct {
        logic                  we;
        logic                  lock;
        logic [ADDR_WIDTH-1:0] addr;
        word_t                 wdata;
    } txn_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic preload = 1'b1;

    always #5 clk = ~clk;

    dmem_req_if core_if ();
    dmem_req_if dma_if ();

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    word_t                 mem_wdata;
    word_t                 mem_rdata;
    word_t                 mem [MEM_SIZE];

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_core_grants, perf_dma_grants, perf_conflicts;
`endif

    dmem_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .core      (core_if),
        .dma       (dma_if),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_core_grants (perf_core_grants),
        .perf_dma_grants  (perf_dma_grants),
        .perf_conflicts   (perf_conflicts)
`endif
    );

    function automatic word_t init_word(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Synchronous single-port memory, registered read, read-before-write
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MEM_SIZE; i++) mem[i] <= init_word(i);
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        else n_pass++;
    endtask

    // ---------------- reference model and per-cycle compare ----------------
    word_t m_mem [MEM_SIZE];
    int    m_last, m_holder, m_streak, m_owner;
    bit    m_pend;
    word_t m_data;
    int    m_pc, m_pd, m_pf;
    int    cyc_n = 0;
    string grant_log = "";
    word_t core_rsp_log[$], dma_rsp_log[$];
    int    core_grant_cyc[$], core_rsp_cyc[$];

    always @(negedge clk) begin : p_compare
        logic     cv, dv, g, wlock, ovalid;
        int       w;
        mem_req_t exp_req;
        cyc_n++;
        if (preload) for (int i = 0; i < MEM_SIZE; i++) m_mem[i] = init_word(i);
        if (!rst_n) begin
            check("rst_core_ready", 32'(core_if.req_ready), 0);
            check("rst_dma_ready",  32'(dma_if.req_ready),  0);
            check("rst_mem_we",     32'(mem_we),            0);
            check("rst_core_rsp",   32'(core_if.rsp_valid), 0);
            check("rst_dma_rsp",    32'(dma_if.rsp_valid),  0);
            m_last = 1; m_holder = -1; m_streak = 0; m_pend = 1'b0;
            m_pc = 0; m_pd = 0; m_pf = 0;
        end else begin
            cv = core_if.req_valid;
            dv = dma_if.req_valid;
            g  = cv | dv;
            if (cv && dv) w = (m_holder >= 0 && m_streak < MAX_LOCK) ? m_holder : 1 - m_last;
            else          w = dv ? 1 : 0;
            exp_req = '0;
            if (g && w == 0) exp_req = '{core_if.req_we, core_if.req_addr, core_if.req_wdata};
            if (g && w == 1) exp_req = '{dma_if.req_we, dma_if.req_addr, dma_if.req_wdata};

            check("core_ready", 32'(core_if.req_ready), 32'(g && w == 0));
            check("dma_ready",  32'(dma_if.req_ready),  32'(g && w == 1));
            check("mem_we",     32'(mem_we),            32'(exp_req.we));
            check("mem_addr",   32'(mem_addr),          32'(exp_req.addr));
            check("mem_wdata",  mem_wdata,              exp_req.wdata);
            check("core_rsp_valid", 32'(core_if.rsp_valid), 32'(m_pend && m_owner == 0));
            check("dma_rsp_valid",  32'(dma_if.rsp_valid),  32'(m_pend && m_owner == 1));
            check("core_rsp_rdata", core_if.rsp_rdata, (m_pend && m_owner == 0) ? m_data : 32'h0);
            check("dma_rsp_rdata",  dma_if.rsp_rdata,  (m_pend && m_owner == 1) ? m_data : 32'h0);
`ifdef DMEM_ARB_PERF_EN
            check("perf_core", perf_core_grants, 32'(m_pc));
            check("perf_dma",  perf_dma_grants,  32'(m_pd));
            check("perf_conf", perf_conflicts,   32'(m_pf));
`endif
            if (core_if.rsp_valid) begin
                core_rsp_log.push_back(core_if.rsp_rdata);
                core_rsp_cyc.push_back(cyc_n);
            end
            if (dma_if.rsp_valid) dma_rsp_log.push_back(dma_if.rsp_rdata);
            if (core_if.req_ready) begin
                grant_log = {grant_log, "C"};
                core_grant_cyc.push_back(cyc_n);
            end
            if (dma_if.req_ready) grant_log = {grant_log, "D"};

            if (cv && dv) m_pf++;
            m_pend  = g;
            m_owner = w;
            if (g) begin
                if (w == 0) m_pc++; else m_pd++;
                m_data = m_mem[exp_req.addr];
                if (exp_req.we) m_mem[exp_req.addr] = exp_req.wdata;
                wlock  = (w == 0) ? core_if.req_lock : dma_if.req_lock;
                ovalid = (w == 0) ? dv : cv;
                if (m_holder < 0) begin
                    if (wlock) begin m_holder = w; m_streak = 0; end
                end else if (w != m_holder || !wlock) begin
                    m_holder = -1; m_streak = 0;
                end else if (ovalid) begin
                    m_streak++;
                end
                m_last = w;
            end
        end
    end

    // ---------------- stimulus ----------------
    txn_t cq[$], dq[$];

    task automatic drive();
        core_if.req_valid = (cq.size() != 0);
        core_if.req_we    = (cq.size() != 0) ? cq[0].we    : 1'b0;
        core_if.req_lock  = (cq.size() != 0) ? cq[0].lock  : 1'b0;
        core_if.req_addr  = (cq.size() != 0) ? cq[0].addr  : '0;
        core_if.req_wdata = (cq.size() != 0) ? cq[0].wdata : '0;
        dma_if.req_valid  = (dq.size() != 0);
        dma_if.req_we     = (dq.size() != 0) ? dq[0].we    : 1'b0;
        dma_if.req_lock   = (dq.size() != 0) ? dq[0].lock  : 1'b0;
        dma_if.req_addr   = (dq.size() != 0) ? dq[0].addr  : '0;
        dma_if.req_wdata  = (dq.size() != 0) ? dq[0].wdata : '0;
    endtask

    task automatic run(input int budget, input bit must_drain);
        int cyc = 0;
        logic fc, fd;
        drive();
        while ((cq.size() != 0 || dq.size() != 0) && cyc < budget) begin
            @(negedge clk);
            fc = core_if.req_valid & core_if.req_ready;
            fd = dma_if.req_valid & dma_if.req_ready;
            @(posedge clk); #1;
            if (fc) void'(cq.pop_front());
            if (fd) void'(dq.pop_front());
            drive();
            cyc++;
        end
        if (must_drain) check("drain_timeout", 32'(cq.size() + dq.size()), 0);
    endtask

    task automatic do_reset();
        cq.delete(); dq.delete();
        drive();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        preload = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int gb, cb, db, cg;

        // 1: CORE write then read of addr 5
        do_reset();
        cb = core_rsp_log.size(); cg = core_grant_cyc.size();
        cq.push_back('{1'b1, 1'b0, 8'd5, 32'hDEAD_BEEF});
        cq.push_back('{1'b0, 1'b0, 8'd5, 32'h0});
        run(10, 1'b1);
        idle(2);
        check("s1_rsp_count",   32'(core_rsp_log.size() - cb), 2);
        check("s1_write_old",   core_rsp_log[cb],     32'hA500_0005);
        check("s1_read_data",   core_rsp_log[cb + 1], 32'hDEAD_BEEF);
        check("s1_read_latency", 32'(core_rsp_cyc[cb + 1] - core_grant_cyc[cg + 1]), 1);

        // 2/6: both valid, no lock, alternating grants
        do_reset();
        gb = grant_log.len(); cb = core_rsp_log.size(); db = dma_rsp_log.size();
        for (int i = 0; i < 4; i++) cq.push_back('{1'b0, 1'b0, 8'(10 + i), 32'h0});
        for (int i = 0; i < 3; i++) dq.push_back('{1'b0, 1'b0, 8'(20 + i), 32'h0});
        run(6, 1'b0);
        check_str("s2_grant_order", grant_log.substr(gb, gb + 5), "CDCDCD");
`ifdef DMEM_ARB_PERF_EN
        check("s6_perf_core", perf_core_grants, 3);
        check("s6_perf_dma",  perf_dma_grants,  3);
        check("s6_perf_conf", perf_conflicts,   6);
`endif
        run(10, 1'b1);
        idle(2);
        check("s2_core_rsp0", core_rsp_log[cb],     32'hA500_000A);
        check("s2_core_rsp3", core_rsp_log[cb + 3], 32'hA500_000D);
        check("s2_dma_rsp2",  dma_rsp_log[db + 2],  32'hA500_0016);

        // 3: CORE lock held against a waiting DMA
        do_reset();
        gb = grant_log.len();
        for (int i = 0; i < 5; i++) cq.push_back('{1'b0, 1'b1, 8'(30 + i), 32'h0});
        cq.push_back('{1'b0, 1'b0, 8'd35, 32'h0});
        dq.push_back('{1'b0, 1'b0, 8'd40, 32'h0});
        dq.push_back('{1'b0, 1'b0, 8'd41, 32'h0});
        run(20, 1'b1);
        idle(2);
        check_str("s3_lock_order", grant_log.substr(gb, gb + 7), "CCCCCDCD");

        // 4: read-before-write across requesters
        do_reset();
        cb = core_rsp_log.size(); db = dma_rsp_log.size(); gb = grant_log.len();
        cq.push_back('{1'b1, 1'b0, 8'd9, 32'h1234_5678});
        dq.push_back('{1'b0, 1'b0, 8'd9, 32'h0});
        run(10, 1'b1);
        idle(2);
        check_str("s4_order", grant_log.substr(gb, gb + 1), "CD");
        check("s4_core_old", core_rsp_log[cb], 32'hA500_0009);
        check("s4_dma_new",  dma_rsp_log[db],  32'h1234_5678);

        // 5: reset in the cycle after a grant
        do_reset();
        cb = core_rsp_log.size();
        cq.push_back('{1'b1, 1'b0, 8'd3, 32'hCAFE_0003});
        drive();
        @(posedge clk); #1;
        void'(cq.pop_front());
        rst_n = 1'b0;
        cq.push_back('{1'b0, 1'b0, 8'd7, 32'h0});
        dq.push_back('{1'b0, 1'b0, 8'd8, 32'h0});
        drive();
        @(negedge clk);
        check("s5_rsp_valid", 32'(core_if.rsp_valid | dma_if.rsp_valid), 0);
        check("s5_mem_we",    32'(mem_we), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        gb = grant_log.len();
        run(10, 1'b1);
        idle(2);
        check_str("s5_first_conflict", grant_log.substr(gb, gb + 1), "CD");
        check("s5_core_rsp", core_rsp_log[cb], 32'hA500_0007);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
